// File: rtl/move_drain_arbiter.sv
// Drains per-square move stacks into the FPGA-to-CPU FIFO using round-robin arbitration.
// Each grant pops one move, which is held until the FIFO accepts it.
module move_drain_arbiter #(
    parameter int NUM_REQ = 64,
    parameter int IDX_W   = 6,
    parameter int MOVE_W  = 16,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*MOVE_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_pop,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [31:0]               fifo_wdata,
    output logic                      busy,
    output logic                      done,
    output logic [CNT_W-1:0]          move_count
);

    // Handshake: a stack is popped in the same cycle it is granted (req_pop one-hot);
    // a FIFO write happens in any WRITE cycle where fifo_full is low (fifo_wr = ~fifo_full).
    typedef enum logic [1:0] {
        S_IDLE,
        S_ARB,
        S_WRITE,
        S_DONE
    } state_t;

    state_t              state, state_nx;
    logic [IDX_W-1:0]    ptr, ptr_nx;
    logic [IDX_W-1:0]    gidx, gidx_nx;
    logic [MOVE_W-1:0]   hold, hold_nx;
    logic [CNT_W-1:0]    cnt_nx;
    logic [IDX_W-1:0]    grant;
    logic                grant_found;
    logic [IDX_W:0]      search_idx;
    logic [MOVE_W-1:0]   req_words [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_words[k] = req_data[k*MOVE_W +: MOVE_W];
        end
    end

    // Search starts at ptr and wraps, so the first hit is the round-robin winner.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        search_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            search_idx = {1'b0, ptr} + (IDX_W+1)'(i);
            if (search_idx >= (IDX_W+1)'(NUM_REQ)) begin
                search_idx = search_idx - (IDX_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[search_idx[IDX_W-1:0]]) begin
                grant_found = 1'b1;
                grant       = search_idx[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        gidx_nx    = gidx;
        hold_nx    = hold;
        cnt_nx     = move_count;
        req_pop    = '0;
        fifo_wr    = 1'b0;
        fifo_wdata = '0;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_ARB;
                    ptr_nx   = '0;
                    cnt_nx   = '0;
                end
            end
            S_ARB: begin
                if (!grant_found) begin
                    state_nx = S_DONE;
                end else begin
                    req_pop[grant] = 1'b1;
                    hold_nx        = req_words[grant];
                    gidx_nx        = grant;
                    state_nx       = S_WRITE;
                end
            end
            S_WRITE: begin
                fifo_wdata[MOVE_W-1:0] = hold;
                fifo_wr                = !fifo_full;
                if (!fifo_full) begin
                    if (move_count != '1) begin
                        cnt_nx = move_count + 1'b1;
                    end
                    ptr_nx   = (gidx == IDX_W'(NUM_REQ-1)) ? '0 : gidx + 1'b1;
                    state_nx = S_ARB;
                end
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            gidx       <= '0;
            hold       <= '0;
            move_count <= '0;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            gidx       <= gidx_nx;
            hold       <= hold_nx;
            move_count <= cnt_nx;
        end
    end

endmodule

// File: tb/tb_move_drain_arbiter.sv
// Scoreboard bench for move_drain_arbiter: a stack model feeds the DUT, expected FIFO words
// are queued at each pop and compared when the DUT writes.
module tb_move_drain_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [63:0]   req_valid;
    logic [1023:0] req_data;
    logic [63:0]   req_pop;
    logic          fifo_full;
    logic          fifo_wr;
    logic [31:0]   fifo_wdata;
    logic          busy;
    logic          done;
    logic [7:0]    move_count;

    move_drain_arbiter #(.NUM_REQ(64), .IDX_W(6), .MOVE_W(16), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_pop    (req_pop),
        .fifo_full  (fifo_full),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .busy       (busy),
        .done       (done),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    logic [15:0] stk [64][$];
    logic [31:0] exp_q [$];
    logic [31:0] wlog [$];
    int          glog [$];
    int n_checks, n_pass;
    int mptr, mcount, last_g, done_cnt, full_cnt, stall_len, stall_seen;
    int rnd_full, extra_pushes, pushes_done;
    bit pending, saw_done, saw_wr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int model_grant();
        for (int i = 0; i < 64; i++) begin
            int k;
            k = (mptr + i) % 64;
            if (stk[k].size() != 0) return k;
        end
        return -1;
    endfunction

    task automatic refresh();
        for (int k = 0; k < 64; k++) begin
            req_valid[k] = (stk[k].size() != 0);
            req_data[k*16 +: 16] = (stk[k].size() != 0) ? stk[k][0] : 16'hDEAD;
        end
    endtask

    // One clock: sample outputs at negedge, then advance the stack model after the edge.
    task automatic tick();
        int  g;
        bit  pop_now;
        g = -1;
        pop_now = 1'b0;
        saw_done = 1'b0;
        saw_wr = 1'b0;
        @(negedge clk);
        if (req_pop != '0) begin
            check("pop_onehot", 32'($onehot(req_pop)), 32'd1);
            for (int k = 63; k >= 0; k--) if (req_pop[k]) g = k;
            check("grant_idx", g, model_grant());
            if (g >= 0 && stk[g].size() != 0) exp_q.push_back({16'h0, stk[g][0]});
            else check("pop_empty_stack", 32'd1, 32'd0);
            glog.push_back(g);
            last_g = g;
            pending = 1'b1;
            pop_now = 1'b1;
        end
        if (pending && !pop_now) begin
            if (fifo_full) begin
                stall_seen++;
                check("stall_wr", {31'b0, fifo_wr}, 32'd0);
                check("stall_data", fifo_wdata, (exp_q.size() != 0) ? exp_q[0] : 32'hFFFF_FFFF);
            end else begin
                check("wr_strobe", {31'b0, fifo_wr}, 32'd1);
            end
        end
        if (fifo_wr) begin
            saw_wr = 1'b1;
            if (exp_q.size() == 0) check("unexpected_wr", 32'd1, 32'd0);
            else check("wdata", fifo_wdata, exp_q.pop_front());
            wlog.push_back(fifo_wdata);
            pending = 1'b0;
            mptr = (last_g == 63) ? 0 : last_g + 1;
            mcount = (mcount == 255) ? 255 : mcount + 1;
        end else if (!pending) begin
            check("wdata_idle", fifo_wdata, 32'd0);
        end
        if (done) begin
            saw_done = 1'b1;
            done_cnt++;
        end
        @(posedge clk);
        #1;
        if (pop_now && g >= 0 && stk[g].size() != 0) void'(stk[g].pop_front());
        start = 1'b0;
        if (rnd_full != 0) begin
            fifo_full = ($urandom_range(0, 3) == 0);
            if (extra_pushes > 0 && $urandom_range(0, 7) == 0) begin
                stk[$urandom_range(0, 63)].push_back(16'($urandom_range(0, 16'hFFFF)));
                extra_pushes--;
                pushes_done++;
            end
        end else if (pop_now && stall_len > 0) begin
            full_cnt = stall_len;
            stall_len = 0;
            fifo_full = 1'b1;
        end else if (full_cnt > 0) begin
            full_cnt--;
            fifo_full = (full_cnt > 0);
        end
        refresh();
    endtask

    task automatic run_drain(input int mid_start_at, output int done_k, output int first_wr_k);
        wlog.delete();
        glog.delete();
        done_cnt = 0;
        stall_seen = 0;
        done_k = -1;
        first_wr_k = -1;
        start = 1'b1;
        tick();
        mptr = 0;
        mcount = 0;
        for (int k = 1; k <= 5000; k++) begin
            if (k == mid_start_at) start = 1'b1;
            tick();
            if (saw_wr && first_wr_k < 0) first_wr_k = k;
            if (saw_done) begin
                done_k = k;
                break;
            end
        end
        if (done_k < 0) check("drain_timeout", 32'd0, 32'd1);
        check("move_count", 32'(move_count), 32'(mcount));
        tick();
        check("done_single", done_cnt, 32'd1);
        check("idle_busy", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int dk, wk, remaining;
        int t3_exp [4];
        int t5_exp [3];
        t3_exp = '{5, 60, 5, 60};
        t5_exp = '{0, 63, 0};
        n_checks = 0; n_pass = 0; mptr = 0; mcount = 0; last_g = 0;
        done_cnt = 0; full_cnt = 0; stall_len = 0; stall_seen = 0;
        rnd_full = 0; extra_pushes = 0; pushes_done = 0; pending = 1'b0;
        rst = 1'b1; start = 1'b0; fifo_full = 1'b0;
        refresh();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_fifo_wr", {31'b0, fifo_wr}, 32'd0);
        check("rst_wdata", fifo_wdata, 32'd0);
        check("rst_pop_zero", {31'b0, (req_pop == '0)}, 32'd1);
        check("rst_count", 32'(move_count), 32'd0);

        // T1: empty drain
        run_drain(0, dk, wk);
        check("t1_done_lat", dk, 32'd2);
        check("t1_no_wr", wlog.size(), 32'd0);
        check("t1_count", 32'(move_count), 32'd0);

        // T2: two single-move stacks
        stk[3].push_back(16'h1234);
        stk[10].push_back(16'h0ABC);
        refresh();
        run_drain(0, dk, wk);
        check("t2_first_wr_lat", wk, 32'd2);
        check("t2_nwr", wlog.size(), 32'd2);
        check("t2_w0", wlog[0], 32'h0000_1234);
        check("t2_w1", wlog[1], 32'h0000_0ABC);
        check("t2_count", 32'(move_count), 32'd2);

        // T3: alternating grants between two deep stacks
        stk[5].push_back(16'h5001); stk[5].push_back(16'h5002);
        stk[60].push_back(16'h6001); stk[60].push_back(16'h6002);
        refresh();
        run_drain(0, dk, wk);
        check("t3_ngrant", glog.size(), 32'd4);
        for (int i = 0; i < 4; i++) check("t3_grant_order", glog[i], t3_exp[i]);
        check("t3_w2", wlog[2], 32'h0000_5002);

        // T4: FIFO full for three cycles during the first write
        stk[7].push_back(16'h7777);
        stk[8].push_back(16'h8888);
        refresh();
        stall_len = 3;
        run_drain(0, dk, wk);
        check("t4_stall_cycles", stall_seen, 32'd3);
        check("t4_nwr", wlog.size(), 32'd2);
        check("t4_w0", wlog[0], 32'h0000_7777);
        check("t4_w1", wlog[1], 32'h0000_8888);

        // T5: wrap from 63 back to 0, with a start pulse mid-drain
        stk[0].push_back(16'h00A0); stk[0].push_back(16'h00A1);
        stk[63].push_back(16'h00F3);
        refresh();
        run_drain(3, dk, wk);
        check("t5_ngrant", glog.size(), 32'd3);
        for (int i = 0; i < 3; i++) check("t5_grant_order", glog[i], t5_exp[i]);
        check("t5_count", 32'(move_count), 32'd3);

        // T6: reset while a popped move waits in WRITE
        wlog.delete(); glog.delete(); done_cnt = 0;
        stk[2].push_back(16'h2222);
        stk[9].push_back(16'h9999);
        refresh();
        start = 1'b1;
        tick();
        mptr = 0; mcount = 0;
        tick();
        check("t6_first_grant", last_g, 32'd2);
        rst = 1'b1;
        fifo_full = 1'b1;
        tick();
        rst = 1'b0;
        fifo_full = 1'b0;
        exp_q.delete();
        pending = 1'b0;
        check("t6_busy", {31'b0, busy}, 32'd0);
        check("t6_fifo_wr", {31'b0, fifo_wr}, 32'd0);
        check("t6_wdata", fifo_wdata, 32'd0);
        check("t6_pop", {31'b0, (req_pop == '0)}, 32'd1);
        check("t6_done", {31'b0, done}, 32'd0);
        check("t6_count", 32'(move_count), 32'd0);
        check("t6_rst_wr", wlog.size(), 32'd0);
        run_drain(0, dk, wk);
        check("t6_nwr", wlog.size(), 32'd1);
        check("t6_w0", wlog[0], 32'h0000_9999);
        check("t6_count_after", 32'(move_count), 32'd1);

        // T7: random stacks, random backpressure, moves arriving during the drain
        for (int i = 0; i < 40; i++) stk[$urandom_range(0, 63)].push_back(16'($urandom_range(0, 16'hFFFF)));
        refresh();
        rnd_full = 1; extra_pushes = 20; pushes_done = 0;
        run_drain(0, dk, wk);
        rnd_full = 0; extra_pushes = 0; fifo_full = 1'b0;
        remaining = 0;
        for (int k = 0; k < 64; k++) begin
            remaining += stk[k].size();
            stk[k].delete();
        end
        refresh();
        check("t7_nwr", wlog.size(), 40 + pushes_done - remaining);
        check("t7_count", 32'(move_count), wlog.size());

        // T8: one deep stack, counter saturation
        for (int i = 0; i < 300; i++) stk[17].push_back(16'(i));
        refresh();
        run_drain(0, dk, wk);
        check("t8_nwr", wlog.size(), 32'd300);
        check("t8_count_sat", 32'(move_count), 32'd255);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
